// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered, mutually aligned sync outputs.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       Pclk,
    input  logic       rst,
    output logic [9:0] xx,
    output logic [9:0] yy,
    output logic       aactive,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HAct    = 10'(H_ACTIVE);
    localparam logic [9:0] VAct    = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncLo = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncHi = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncLo = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncHi = 10'(V_ACTIVE + V_FP + V_SYNC);

    // h_q/v_q hold the pixel that the next edge will present on the outputs.
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       h_wrap;

    logic aactive_d, hsync_d, vsync_d, frame_start_d, line_start_d;

    always_comb begin
        h_wrap = (h_q == HLast);
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
        end
    end

    always_comb begin
        aactive_d     = (h_q < HAct) && (v_q < VAct);
        hsync_d       = !((h_q >= HSyncLo) && (h_q < HSyncHi));
        vsync_d       = !((v_q >= VSyncLo) && (v_q < VSyncHi));
        frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
        line_start_d  = (h_q == 10'd0);
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            h_q         <= 10'd0;
            v_q         <= 10'd0;
            xx          <= 10'd0;
            yy          <= 10'd0;
            aactive     <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            xx          <= h_q;
            yy          <= v_q;
            aactive     <= aactive_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= frame_start_d;
            line_start  <= line_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // The first frame after reset release keeps the count at zero.
    logic first_q;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
            first_q   <= 1'b1;
        end else if (frame_start_d) begin
            if (first_q) begin
                first_q <= 1'b0;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a default-timing instance for line-level checks and a
// reduced-timing instance for whole-frame checks (frame counter checked when enabled).
module tb_vga_timing;

    // Reduced timing: H_TOTAL 15, V_TOTAL 11, 165 cycles per frame.
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFR = SHT * SVT;

    logic       Pclk = 1'b0;
    logic       rst  = 1'b1;

    logic [9:0] xx, yy, xx_s, yy_s;
    logic       aactive, hsync, vsync, frame_start, line_start;
    logic       aactive_s, hsync_s, vsync_s, frame_start_s, line_start_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt, frame_cnt_s;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #20 Pclk = ~Pclk;

    vga_timing u_dut (
        .Pclk        (Pclk),
        .rst         (rst),
        .xx          (xx),
        .yy          (yy),
        .aactive     (aactive),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .line_start  (line_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    vga_timing #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) u_small (
        .Pclk        (Pclk),
        .rst         (rst),
        .xx          (xx_s),
        .yy          (yy_s),
        .aactive     (aactive_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .frame_start (frame_start_s),
        .line_start  (line_start_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_s)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference for one pixel: 1 when all outputs agree with the timing formulas.
    function automatic bit pix_ok(input int x, input int y, input int ha, input int hf,
                                  input int hs, input int va, input int vf, input int vs,
                                  input logic [9:0] gx, input logic [9:0] gy, input logic ga,
                                  input logic gh, input logic gv, input logic gf, input logic gl);
        bit a, h, v, f, l;
        a = (x < ha) && (y < va);
        h = !((x >= ha + hf) && (x < ha + hf + hs));
        v = !((y >= va + vf) && (y < va + vf + vs));
        f = (x == 0) && (y == 0);
        l = (x == 0);
        return (gx === 10'(x)) && (gy === 10'(y)) && (ga === a) && (gh === h) &&
               (gv === v) && (gf === f) && (gl === l);
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_xx"}, 32'(xx), 0);
        check_eq({pfx, "_yy"}, 32'(yy), 0);
        check_eq({pfx, "_aactive"}, 32'(aactive), 0);
        check_eq({pfx, "_hsync"}, 32'(hsync), 1);
        check_eq({pfx, "_vsync"}, 32'(vsync), 1);
        check_eq({pfx, "_frame_start"}, 32'(frame_start), 0);
        check_eq({pfx, "_line_start"}, 32'(line_start), 0);
        check_eq({pfx, "_small_xx"}, 32'(xx_s), 0);
        check_eq({pfx, "_small_hsync"}, 32'(hsync_s), 1);
    endtask

    initial begin
        int err, act, hs_lo, hs_min, hs_max, ls_cnt, ls_first, ls_second;
        int fs_cnt, fs_first, fs_second, vs_lo, vs_min, vs_max, vs_bad;
        logic vs_prev;

        // Three edges with reset high, then release.
        rst = 1'b1;
        repeat (3) @(negedge Pclk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge Pclk);
        check_eq("first_xx", 32'(xx), 0);
        check_eq("first_yy", 32'(yy), 0);
        check_eq("first_aactive", 32'(aactive), 1);
        check_eq("first_frame_start", 32'(frame_start), 1);
        check_eq("first_line_start", 32'(line_start), 1);
        check_eq("first_hsync", 32'(hsync), 1);
        check_eq("first_vsync", 32'(vsync), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_eq("first_frame_cnt", 32'(frame_cnt), 0);
`endif

        // Two full default lines against the reference.
        err = 0; act = 0; hs_lo = 0; hs_min = 9999; hs_max = -1;
        ls_cnt = 0; ls_first = -1; ls_second = -1;
        for (int i = 0; i < 1600; i++) begin
            if (!pix_ok(i % 800, i / 800, 640, 16, 96, 480, 10, 2,
                        xx, yy, aactive, hsync, vsync, frame_start, line_start)) err++;
            if (line_start) begin
                if (ls_first < 0) ls_first = i;
                else if (ls_second < 0) ls_second = i;
            end
            if (i < 800) begin
                if (aactive) act++;
                if (!hsync) begin
                    hs_lo++;
                    if (int'(xx) < hs_min) hs_min = int'(xx);
                    if (int'(xx) > hs_max) hs_max = int'(xx);
                end
                if (line_start) ls_cnt++;
            end
            if (i == 639) check_eq("x639_aactive", 32'(aactive), 1);
            if (i == 640) begin
                check_eq("x640_xx", 32'(xx), 640);
                check_eq("x640_aactive", 32'(aactive), 0);
            end
            @(negedge Pclk);
        end
        check_eq("line_model_errors", 32'(err), 0);
        check_eq("line_aactive_cnt", 32'(act), 640);
        check_eq("line_hsync_low_cnt", 32'(hs_lo), 96);
        check_eq("line_hsync_first_x", 32'(hs_min), 656);
        check_eq("line_hsync_last_x", 32'(hs_max), 751);
        check_eq("line_start_per_line", 32'(ls_cnt), 1);
        check_eq("line_start_period", 32'(ls_second - ls_first), 800);
        check_eq("line2_yy", 32'(yy), 2);

        // Mid-frame reset for one cycle.
        repeat (300) @(negedge Pclk);
        check_eq("pre_reset_xx", 32'(xx), 300);
        rst = 1'b1;
        @(negedge Pclk);
        check_reset_vals("midreset");
        rst = 1'b0;
        @(negedge Pclk);
        check_eq("restart_xx", 32'(xx), 0);
        check_eq("restart_yy", 32'(yy), 0);
        check_eq("restart_frame_start", 32'(frame_start), 1);
        @(negedge Pclk);
        check_eq("restart_next_xx", 32'(xx), 1);
        check_eq("restart_next_frame_start", 32'(frame_start), 0);

        // Realign and run two reduced-timing frames.
        rst = 1'b1;
        @(negedge Pclk);
        rst = 1'b0;
        @(negedge Pclk);
        err = 0; act = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        vs_lo = 0; vs_min = 9999; vs_max = -1; vs_bad = 0; vs_prev = vsync_s;
        for (int i = 0; i < 2 * SFR; i++) begin
            if (!pix_ok(i % SHT, (i / SHT) % SVT, SHA, SHF, SHS, SVA, SVF, SVS,
                        xx_s, yy_s, aactive_s, hsync_s, vsync_s, frame_start_s, line_start_s))
                err++;
            if (frame_start_s) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (vsync_s !== vs_prev && xx_s != 10'd0) vs_bad++;
            vs_prev = vsync_s;
            if (i < SFR) begin
                if (aactive_s) act++;
                if (frame_start_s) fs_cnt++;
                if (!vsync_s) begin
                    vs_lo++;
                    if (int'(yy_s) < vs_min) vs_min = int'(yy_s);
                    if (int'(yy_s) > vs_max) vs_max = int'(yy_s);
                end
            end
            if (i == (SVA - 1) * SHT + SHA - 1) begin
                check_eq("small_last_vis_xx", 32'(xx_s), SHA - 1);
                check_eq("small_last_vis_aactive", 32'(aactive_s), 1);
            end
            if (i == (SVA - 1) * SHT + SHA) begin
                check_eq("small_after_vis_xx", 32'(xx_s), SHA);
                check_eq("small_after_vis_yy", 32'(yy_s), SVA - 1);
                check_eq("small_after_vis_aactive", 32'(aactive_s), 0);
            end
            if (i == SFR - 1) begin
                check_eq("small_end_xx", 32'(xx_s), SHT - 1);
                check_eq("small_end_yy", 32'(yy_s), SVT - 1);
            end
            if (i == SFR) begin
                check_eq("small_wrap_xx", 32'(xx_s), 0);
                check_eq("small_wrap_yy", 32'(yy_s), 0);
                check_eq("small_wrap_frame_start", 32'(frame_start_s), 1);
            end
            @(negedge Pclk);
        end
        check_eq("frame_model_errors", 32'(err), 0);
        check_eq("frame_aactive_cnt", 32'(act), SHA * SVA);
        check_eq("frame_start_per_frame", 32'(fs_cnt), 1);
        check_eq("frame_start_period", 32'(fs_second - fs_first), SFR);
        check_eq("frame_vsync_low_cnt", 32'(vs_lo), SVS * SHT);
        check_eq("frame_vsync_first_y", 32'(vs_min), SVA + SVF);
        check_eq("frame_vsync_last_y", 32'(vs_max), SVA + SVF + SVS - 1);
        check_eq("frame_vsync_edge_off_x0", 32'(vs_bad), 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        // 257 reduced frames from reset: count is frame number minus one, modulo 256.
        rst = 1'b1;
        @(negedge Pclk);
        rst = 1'b0;
        @(negedge Pclk);
        err = 0;
        for (int k = 1; k <= 257; k++) begin
            if (frame_start_s !== 1'b1 || frame_cnt_s !== 8'(k - 1)) err++;
            if (k == 1) check_eq("frame_cnt_f1", 32'(frame_cnt_s), 0);
            if (k == 2) check_eq("frame_cnt_f2", 32'(frame_cnt_s), 1);
            if (k == 257) check_eq("frame_cnt_f257", 32'(frame_cnt_s), 0);
            repeat (SFR / 2) @(negedge Pclk);
            if (frame_cnt_s !== 8'(k - 1)) err++;
            repeat (SFR - SFR / 2) @(negedge Pclk);
        end
        check_eq("frame_cnt_sequence_errors", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have port Pclk, input, 1, 25 MHz pixel clock; single clock domain, all logic on rising edge.
REQ-010 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-011 The block SHALL have port xx, output, 10, current pixel column (0..H_TOTAL-1).
REQ-012 The block SHALL have port yy, output, 10, current line (0..V_TOTAL-1).
REQ-013 The block SHALL have port aactive, output, 1, high while the current pixel is visible.
REQ-014 The block SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-015 The block SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-016 The block SHALL have port frame_start, output, 1, one-cycle pulse at pixel (0,0).
REQ-017 The block SHALL have port line_start, output, 1, one-cycle pulse when xx==0 on any line.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
REQ-019 An internal horizontal counter SHALL advance by 1 every Pclk cycle and wrap from H_TOTAL-1 to 0.
REQ-020 An internal vertical counter SHALL advance by 1 only in the cycle the horizontal counter wraps, and wrap from V_TOTAL-1 to 0 when both wrap together.
REQ-021 All outputs SHALL be registered and mutually aligned: on each edge, every output is updated from the same counter pair, so xx/yy/aactive/hsync/vsync/frame_start/line_start always describe the same pixel.
REQ-022 aactive SHALL be 1 iff xx<H_ACTIVE and yy<V_ACTIVE.
REQ-023 hsync SHALL be 0 iff H_ACTIVE+H_FP <= xx < H_ACTIVE+H_FP+H_SYNC (656..751 default), else 1.
REQ-024 vsync SHALL be 0 iff V_ACTIVE+V_FP <= yy < V_ACTIVE+V_FP+V_SYNC (490..491 default), else 1; vsync transitions SHALL coincide with xx==0.
REQ-025 frame_start SHALL be 1 iff xx==0 and yy==0; line_start SHALL be 1 iff xx==0.
REQ-026 Outputs SHALL present pixel (0,0) on the first Pclk edge with rst low, then (1,0), (2,0), ...; after (799,524) the next pixel SHALL be (0,0).
REQ-027 Comparisons SHALL be unsigned 10-bit; counters never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-028 While rst is sampled high: counters SHALL be 0, xx=0, yy=0, aactive=0, hsync=1, vsync=1, frame_start=0, line_start=0.
REQ-029 Reset asserted mid-frame SHALL take effect on the next edge, abandoning the frame; release restarts at (0,0) per REQ-026.

Configuration
REQ-030 With macro VGA_TIMING_FRAME_CNT_EN defined, the block SHALL add output frame_cnt, 8 bits, reset 0, incrementing by 1 (wrapping 255->0) on each edge where frame_start becomes 1, except the first frame after reset release (stays 0).
REQ-031 Without VGA_TIMING_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Release rst after 3 cycles -> first edge: xx=0, yy=0, aactive=1, frame_start=1, line_start=1, hsync=1, vsync=1.
REQ-033 Run one line -> aactive high exactly 640 cycles, hsync low exactly cycles xx=656..751, line_start period 800 cycles.
REQ-034 Run one full frame -> frame_start period exactly 420000 cycles; vsync low exactly 1600 cycles spanning yy=490..491; aactive count 307200.
REQ-035 Check wrap -> (639,479) followed by (640,479) with aactive=0; (799,524) followed by (0,0) with frame_start=1.
REQ-036 Assert rst for 1 cycle at (300,200) -> next edge all outputs at reset values; after release sequence restarts at (0,0).
REQ-037 With VGA_TIMING_FRAME_CNT_EN: run 257 frames from reset -> frame_cnt reads 0 in frame 1, 1 in frame 2, wraps to 0 at frame 257.
